// File: rtl/axis_fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side AXI4-Stream adapter:
// output-stage state encoding and default sizes.
package axis_fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int FIFO_DEPTH = 2048;

endpackage

// File: rtl/axis_fifo_reader_if.sv
// Bundles the FIFO read port and the AXI4-Stream master signals of the reader.
// master: the reader's view; slave: the FIFO/sink environment's view.
interface axis_fifo_reader_if
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_last;
  logic              fifo_empty;
  logic              fifo_re_en;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    input  fifo_data, fifo_last, fifo_empty, m_axis_tready,
    output fifo_re_en, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output fifo_data, fifo_last, fifo_empty, m_axis_tready,
    input  fifo_re_en, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/axis_fifo_reader.sv
// Drains a combinational-read FIFO into a registered two-entry AXI4-Stream output stage.
// Optional completed-packet counter enabled by defining AXIS_PKT_CNT_EN.
module axis_fifo_reader
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PKT_CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_fifo_reader_if.master   bus
`ifdef AXIS_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_count
`endif
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [DATA_W-1:0] main_data_r;
  logic [DATA_W-1:0] main_data_nxt_s;
  logic              main_last_r;
  logic              main_last_nxt_s;
  logic [DATA_W-1:0] skid_data_r;
  logic [DATA_W-1:0] skid_data_nxt_s;
  logic              skid_last_r;
  logic              skid_last_nxt_s;
  logic              tvalid_r;
  logic              rd_s;
  logic              pop_s;

  // Read strobe sees only the FIFO flag and registered state, never tready.
  assign rd_s  = !bus.fifo_empty && (state_r != S_TWO);
  assign pop_s = tvalid_r && bus.m_axis_tready;

  assign bus.fifo_re_en    = rd_s;
  assign bus.m_axis_tvalid = tvalid_r;
  assign bus.m_axis_tdata  = main_data_r;
  assign bus.m_axis_tlast  = main_last_r;

  // Next-state and register-load selection for the output stage.
  always_comb begin
    state_nxt_s     = state_r;
    main_data_nxt_s = main_data_r;
    main_last_nxt_s = main_last_r;
    skid_data_nxt_s = skid_data_r;
    skid_last_nxt_s = skid_last_r;
    case (state_r)
      S_EMPTY: begin
        if (rd_s) begin
          state_nxt_s     = S_ONE;
          main_data_nxt_s = bus.fifo_data;
          main_last_nxt_s = bus.fifo_last;
        end else begin
          state_nxt_s = S_EMPTY;
        end
      end
      S_ONE: begin
        if (rd_s && pop_s) begin
          state_nxt_s     = S_ONE;
          main_data_nxt_s = bus.fifo_data;
          main_last_nxt_s = bus.fifo_last;
        end else if (rd_s) begin
          state_nxt_s     = S_TWO;
          skid_data_nxt_s = bus.fifo_data;
          skid_last_nxt_s = bus.fifo_last;
        end else if (pop_s) begin
          state_nxt_s = S_EMPTY;
        end else begin
          state_nxt_s = S_ONE;
        end
      end
      S_TWO: begin
        // The skid entry is older than anything still in the FIFO, so it refills main.
        if (pop_s) begin
          state_nxt_s     = S_ONE;
          main_data_nxt_s = skid_data_r;
          main_last_nxt_s = skid_last_r;
        end else begin
          state_nxt_s = S_TWO;
        end
      end
      default: begin
        state_nxt_s = S_EMPTY;
      end
    endcase
  end

  // Output-stage registers; tvalid is registered alongside the state it mirrors.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= S_EMPTY;
      main_data_r <= {DATA_W{1'b0}};
      main_last_r <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_last_r <= 1'b0;
      tvalid_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_data_r <= main_data_nxt_s;
      main_last_r <= main_last_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_last_r <= skid_last_nxt_s;
      tvalid_r    <= (state_nxt_s != S_EMPTY);
    end
  end

`ifdef AXIS_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_r;

  // Counts accepted end-of-packet beats, wrapping naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_r <= {PKT_CNT_W{1'b0}};
    end else if (pop_s && main_last_r) begin
      pkt_cnt_r <= pkt_cnt_r + PKT_CNT_W'(1);
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign pkt_count = pkt_cnt_r;
`endif

endmodule

// File: doc/axis_fifo_reader.md
Name: axis_fifo_reader

Overview:
Read-side adapter between the 2048-entry FIFO core and a downstream AXI4-Stream master interface. It drains the FIFO through its combinational read port (data/last valid at the current read pointer, pointer advances on re_en) and presents beats on m_axis_*. A two-entry registered output stage keeps fifo_re_en free of any combinational path from m_axis_tready. Full throughput is one beat per cycle when the FIFO is non-empty and the sink is ready.

Parameters:
DATA_W, 8, width of fifo_data / m_axis_tdata
PKT_CNT_W, 16, width of pkt_count (used only when AXIS_PKT_CNT_EN is defined)

Ports:
aclk  input  1  clock; all logic on rising edge
aresetn  input  1  reset, asynchronous, active-low
fifo_data  input  DATA_W  FIFO read data at current read pointer (combinational from FIFO)
fifo_last  input  1  FIFO tlast at current read pointer
fifo_empty  input  1  FIFO empty flag
fifo_re_en  output  1  FIFO read strobe; FIFO pops on the edge where this is high
m_axis_tdata  output  DATA_W  stream data (registered)
m_axis_tlast  output  1  stream end-of-packet (registered)
m_axis_tvalid  output  1  stream valid (registered)
m_axis_tready  input  1  stream ready from sink
pkt_count  output  PKT_CNT_W  completed-packet counter (present only with AXIS_PKT_CNT_EN)

Behaviour:
- Storage: main register {main_data, main_last} drives m_axis_*; skid register {skid_data, skid_last}.
- State (2-bit): S_EMPTY (no beat held), S_ONE (main valid), S_TWO (main and skid valid).
- rd = fifo_re_en = !fifo_empty && (state != S_TWO). Depends only on fifo_empty and registered state.
- pop = m_axis_tvalid && m_axis_tready.
- S_EMPTY: rd -> S_ONE, main <= fifo. Otherwise hold.
- S_ONE: rd&pop -> S_ONE, main <= fifo. rd&!pop -> S_TWO, skid <= fifo. !rd&pop -> S_EMPTY. !rd&!pop -> hold.
- S_TWO: pop -> S_ONE, main <= skid. !pop -> hold. rd is 0 by construction.
- m_axis_tvalid = (state != S_EMPTY). m_axis_tdata = main_data. m_axis_tlast = main_last.
- AXIS rules:
  - Once tvalid is high, tdata/tlast are stable and tvalid stays high until pop.
  - Beat order matches FIFO order exactly. No beat is dropped or duplicated.
- Latency: FIFO goes non-empty in cycle N (rd=1) -> tvalid=1 with that beat in cycle N+1.
- Backpressure: tready low for any duration -> at most 2 beats are absorbed, then fifo_re_en=0 until the next pop.
- fifo_empty while in S_ONE/S_TWO: the held beats are still delivered and the state drains to S_EMPTY.
- Reset values (async assert, synchronous-to-aclk release): state=S_EMPTY, fifo_re_en=0 (follows state), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, skid=0, pkt_count=0.
- Reset mid-packet: beats held in main/skid are discarded. The FIFO is reset by the same aresetn.
- No width arithmetic except pkt_count, which increments by 1 and wraps modulo 2^PKT_CNT_W.

Optional Feature:
AXIS_PKT_CNT_EN
- Defined: pkt_count port exists. It increments on every cycle where pop && m_axis_tlast, and wraps from all-ones to 0.
- Undefined: the pkt_count port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package axis_fifo_pkg:
  - state encoding constants S_EMPTY=2'd0, S_ONE=2'd1, S_TWO=2'd2
  - default constants DATA_W=8, FIFO_DEPTH=2048
- No sub-module. The state machine and the two registers are small enough for a single module.

Test Plan:
- Reset then load FIFO with 0x11,0x22,0x33 (last on 0x33), tready=1 -> tvalid from the cycle after the first read; beats 0x11,0x22,0x33 on consecutive cycles; tlast only with 0x33; pkt_count=1.
- FIFO holding 5 beats, tready=0 -> exactly 2 fifo_re_en pulses, then fifo_re_en=0; tdata=beat0 held stable. Raise tready -> beats 0..4 in order, no gaps after the first pop.
- Toggle tready every cycle over a 16-beat packet (0x00..0x0F) -> all 16 beats delivered in order, no duplicates, tlast on 0x0F.
- fifo_empty toggling 1-on/1-off, tready=1 -> tvalid pulses match FIFO availability; data order is preserved.
- aresetn low while in S_TWO -> tvalid, tdata and tlast go to 0 immediately (asynchronously). After release, a new beat 0xA5 appears 1 cycle after its FIFO read.
- With AXIS_PKT_CNT_EN and PKT_CNT_W=4, send 17 single-beat packets -> pkt_count=1 (wrap verified).
